// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: glyph table, blank pattern and lookup helper.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-high gfedcba glyphs; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] glyph_of(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex nibble to active-high gfedcba glyph.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    // Table lookup through the package helper.
    always_comb begin
        glyph = glyph_of(nib);
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Self-clocked N-digit multiplexed seven-segment driver for common-anode
// displays: prescaler, digit scan, guard interval, frame-synchronous shadow
// of display data, per-digit blink and leading-zero suppression.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 50000,
    parameter int GUARD        = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     les,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            segment,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]         c;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   sh_hex;
    logic [DIGITS-1:0]     sh_point;
    logic [DIGITS-1:0]     sh_les;
    logic [DIGITS-1:0]     sh_blink;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;
    logic                  load_pending;

    logic                  slot_end;
    logic                  frame_end;
    logic                  guarded;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     upper_zero;
    logic [DIGITS-1:0]     an_nxt;
    logic [7:0]            seg_nxt;

    // Slot and frame boundary decode.
    always_comb begin
        slot_end  = (c == CW'(CLK_DIV - 1));
        frame_end = slot_end && (idx == IW'(DIGITS - 1));
        guarded   = (c < CW'(GUARD));
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c   <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                c   <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    // Shadow registers: loaded once after reset and then only at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hex       <= '0;
            sh_point     <= '0;
            sh_les       <= '0;
            sh_blink     <= '0;
            load_pending <= 1'b1;
        end else begin
            if (load_pending || frame_end) begin
                sh_hex   <= hexs;
                sh_point <= point;
                sh_les   <= les;
                sh_blink <= blink_en;
            end
            load_pending <= 1'b0;
        end
    end

    // Blink half-period counter, advanced once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Nibble of the digit currently being scanned.
    always_comb begin
        nib = sh_hex[{idx, 2'b00} +: 4];
    end

    seg7_glyph_rom u_rom (
        .nib   (nib),
        .glyph (glyph)
    );

    // Digit i is a leading zero when it and every higher digit are zero.
    always_comb begin
        upper_zero = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            upper_zero[k] = ((sh_hex >> (4 * k)) == '0);
        end
    end

    // Next anode/segment pattern with blank priority: les/blink, then zero suppression.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        if (!guarded) begin
            an_nxt[idx] = 1'b0;
            if (sh_les[idx] || (sh_blink[idx] && blink_phase)) begin
                seg_nxt = SEG_BLANK;
            end else if (lz_blank && (idx != '0) && upper_zero[idx]) begin
                seg_nxt = {~sh_point[idx], 7'h7F};
            end else begin
                seg_nxt = ~{sh_point[idx], glyph};
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            segment    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            segment    <= seg_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n: slot-position model checked every cycle plus
// directed literal expectations.
module tb_seg7_scan_n;

    localparam int DG    = 4;
    localparam int CK    = 4;
    localparam int GD    = 1;
    localparam int BF    = 2;
    localparam int FRAME = DG * CK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] hexs = 16'h1234;
    logic [3:0]  point = 4'b0000;
    logic [3:0]  les = 4'b0000;
    logic [3:0]  blink_en = 4'b0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic        frame_done;

    int nvec = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seg7_scan_n #(
        .DIGITS       (DG),
        .CLK_DIV      (CK),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hexs       (hexs),
        .point      (point),
        .les        (les),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .an         (an),
        .segment    (segment),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Independent glyph table, gfedcba active high.
    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: p counts clock edges since reset release; everything else is
    // derived arithmetically from p and the data captured at frame starts.
    int          p;
    logic [15:0] mh;
    logic [3:0]  mp, ml, mb;
    logic [3:0]  ean;
    logic [7:0]  eseg;
    logic        efd;

    always @(posedge clk or negedge rst_n) begin : model
        int cc, d, f;
        logic ph;
        if (!rst_n) begin
            p    <= 0;
            mh   <= '0;
            mp   <= '0;
            ml   <= '0;
            mb   <= '0;
            ean  <= 4'hF;
            eseg <= 8'hFF;
            efd  <= 1'b0;
        end else begin
            cc = p % CK;
            d  = (p / CK) % DG;
            f  = p / FRAME;
            ph = ((f / BF) % 2) == 1;
            efd <= (p % FRAME) == FRAME - 1;
            if (cc < GD) begin
                ean  <= 4'hF;
                eseg <= 8'hFF;
            end else begin
                ean <= ~(4'b0001 << d);
                if (ml[d] || (mb[d] && ph))
                    eseg <= 8'hFF;
                else if (lz_blank && d != 0 && (mh >> (4 * d)) == 16'h0)
                    eseg <= {~mp[d], 7'h7F};
                else
                    eseg <= ~{mp[d], gl[(mh >> (4 * d)) & 16'hF]};
            end
            if (p == 0 || (p % FRAME) == FRAME - 1) begin
                mh <= hexs;
                mp <= point;
                ml <= les;
                mb <= blink_en;
            end
            p <= p + 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if (an !== ean || segment !== eseg || frame_done !== efd) begin
                errors++;
                $display("FAIL cycle t=%0t: an=%b seg=%h fd=%b, required an=%b seg=%h fd=%b",
                         $time, an, segment, frame_done, ean, eseg, efd);
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Wait for the first lit cycle of digit d and return its segment value.
    task automatic capture(input int d, output logic [7:0] s);
        logic [3:0] pat;
        bit found;
        pat = ~(4'b0001 << d);
        found = 1'b0;
        s = 8'hxx;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an == pat) begin
                found = 1'b1;
                s = segment;
            end
        end
        if (!found) begin
            nvec++;
            errors++;
            $display("FAIL capture digit %0d: an never became %b, last an=%b", d, pat, an);
        end
    endtask

    task automatic wait_fd();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1'b1;
        end
        if (!found) begin
            nvec++;
            errors++;
            $display("FAIL frame_done timeout: got 0, required a pulse");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        int cnt_on, cnt_off, nfd;

        // 1. Reset and first digit
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check8("reset an", {4'h0, an}, 8'h0F);
        check8("reset seg", segment, 8'hFF);
        check8("reset fd", {7'h0, frame_done}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check8("first guard an", {4'h0, an}, 8'h0F);
        @(negedge clk);
        check8("first digit an", {4'h0, an}, 8'h0E);
        check8("first digit seg", segment, 8'h99);

        // 2. Free-run scan
        capture(3, s);
        check8("digit3 of 1234", s, 8'hF9);
        nfd = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_done) nfd++;
        end
        check8("frame_done per 32 cycles", 8'(nfd), 8'd2);
        repeat (8) @(negedge clk);

        // 3. Shadowing across a mid-frame change
        capture(1, s);
        check8("digit1 of 1234", s, 8'hB0);
        hexs = 16'h5678;
        capture(2, s);
        check8("digit2 still old", s, 8'hA4);
        capture(3, s);
        check8("digit3 still old", s, 8'hF9);
        wait_fd();
        capture(0, s);
        check8("digit0 new", s, 8'h80);
        capture(3, s);
        check8("digit3 new", s, 8'h92);

        // 4. Leading-zero suppression
        hexs = 16'h0050;
        point = 4'b1000;
        lz_blank = 1'b1;
        wait_fd();
        capture(0, s);
        check8("lz digit0", s, 8'hC0);
        capture(1, s);
        check8("lz digit1", s, 8'h92);
        capture(2, s);
        check8("lz digit2", s, 8'hFF);
        capture(3, s);
        check8("lz digit3", s, 8'h7F);
        lz_blank = 1'b0;
        wait_fd();
        capture(2, s);
        check8("nolz digit2", s, 8'hC0);
        capture(3, s);
        check8("nolz digit3", s, 8'h40);

        // 5. Blink and forced blank
        hexs = 16'h0008;
        point = 4'b0000;
        blink_en = 4'b0001;
        wait_fd();
        cnt_on = 0;
        cnt_off = 0;
        for (int i = 0; i < 8; i++) begin
            wait_fd();
            capture(0, s);
            if (s == 8'h80) cnt_on++;
            if (s == 8'hFF) cnt_off++;
        end
        check8("blink frames on", 8'(cnt_on), 8'd4);
        check8("blink frames off", 8'(cnt_off), 8'd4);
        les = 4'b0001;
        wait_fd();
        cnt_off = 0;
        for (int i = 0; i < 4; i++) begin
            wait_fd();
            capture(0, s);
            if (s == 8'hFF) cnt_off++;
        end
        check8("les frames blank", 8'(cnt_off), 8'd4);

        // 6. Mid-frame asynchronous reset
        les = 4'b0000;
        blink_en = 4'b0000;
        hexs = 16'h00A7;
        wait_fd();
        capture(2, s);
        #2 rst_n = 1'b0;
        #1;
        check8("async reset an", {4'h0, an}, 8'h0F);
        check8("async reset seg", segment, 8'hFF);
        check8("async reset fd", {7'h0, frame_done}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check8("post-reset guard an", {4'h0, an}, 8'h0F);
        capture(0, s);
        check8("post-reset digit0", s, 8'hF8);
        capture(1, s);
        check8("post-reset digit1", s, 8'h88);
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
        $finish;
    end

endmodule
